// File: rtl/md5_bf_pkg.sv
// Shared types and constants for the MD5 brute-force dispatcher.
package md5_bf_pkg;

    localparam int unsigned MSG_W      = 512;
    localparam int unsigned CHAR_FIRST = 32;
    localparam int unsigned CHAR_LAST  = 126;

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StDrain,
        StFinish
    } state_t;

    // Byte k of the block sits at bits [MSG_W-1-8k -: 8] (byte 0 is the MSB).
    function automatic logic [MSG_W-1:0] insert_byte(input logic [MSG_W-1:0] msg,
                                                     input int unsigned      pos,
                                                     input logic [7:0]       value);
        logic [MSG_W-1:0] res;
        res = msg;
        res[MSG_W-1-8*pos -: 8] = value;
        return res;
    endfunction

endpackage

// File: rtl/md5_bf_dispatcher_if.sv
// Processor-side and engine-side signals of the dispatcher, bundled with modports.
interface md5_bf_dispatcher_if #(
    parameter int unsigned NUM_CORES = 4
) ();

    logic                                   start;
    logic                                   abort;
    logic [md5_bf_pkg::MSG_W-1:0]           start_str;
    logic [NUM_CORES-1:0]                   core_reset;
    logic [NUM_CORES-1:0]                   core_ce;
    logic [NUM_CORES*md5_bf_pkg::MSG_W-1:0] core_start_str;
    logic [NUM_CORES-1:0]                   core_done;
    logic [NUM_CORES-1:0]                   core_find;
    logic [NUM_CORES*md5_bf_pkg::MSG_W-1:0] core_result;
    logic                                   busy;
    logic                                   job_done;
    logic                                   found;
    logic [md5_bf_pkg::MSG_W-1:0]           result_str;
    logic [2:0]                             found_core;
    logic [7:0]                             chars_issued;

    modport master (
        output start, abort, start_str, core_done, core_find, core_result,
        input  core_reset, core_ce, core_start_str, busy, job_done, found, result_str,
               found_core, chars_issued
    );

    modport slave (
        input  start, abort, start_str, core_done, core_find, core_result,
        output core_reset, core_ce, core_start_str, busy, job_done, found, result_str,
               found_core, chars_issued
    );

endinterface

// File: rtl/md5_bf_prio_enc.sv
// Lowest-index-set priority encoder: valid flag plus index of the first set request.
module md5_bf_prio_enc #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WIDTH-1:0] i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/md5_bf_dispatcher.sv
// Hands prefix characters to free MD5 engines, stops all engines on the first match.
module md5_bf_dispatcher
    import md5_bf_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned PREFIX_BYTE = 0,
    parameter int unsigned FROM_CHAR   = CHAR_FIRST,
    parameter int unsigned TO_CHAR     = CHAR_LAST
) (
    input logic               i_clk,
    input logic               i_reset,
    md5_bf_dispatcher_if.slave bus
);

    state_t                       r_state;
    logic [MSG_W-1:0]             r_template;
    logic [7:0]                   r_next_char;
    logic [7:0]                   r_chars_issued;
    logic [NUM_CORES-1:0]         r_free;
    logic [NUM_CORES-1:0]         r_core_ce;
    logic [NUM_CORES-1:0]         r_core_reset;
    logic [NUM_CORES*MSG_W-1:0]   r_core_start_str;
    logic                         r_busy;
    logic                         r_job_done;
    logic                         r_found;
    logic [MSG_W-1:0]             r_result_str;
    logic [2:0]                   r_found_core;

    logic                         w_free_valid;
    logic [2:0]                   w_free_idx;
    logic                         w_find_valid;
    logic [2:0]                   w_find_idx;
    logic                         w_can_issue;
    logic [NUM_CORES-1:0]         w_issue;
    logic [NUM_CORES-1:0]         w_done;
    logic [MSG_W-1:0]             w_find_result;
    logic [MSG_W-1:0]             w_prefix_str;

    md5_bf_prio_enc #(
        .WIDTH (NUM_CORES),
        .IDX_W (3)
    ) u_free_enc (
        .i_req   (r_free),
        .o_valid (w_free_valid),
        .o_idx   (w_free_idx)
    );

    md5_bf_prio_enc #(
        .WIDTH (NUM_CORES),
        .IDX_W (3)
    ) u_find_enc (
        .i_req   (bus.core_find),
        .o_valid (w_find_valid),
        .o_idx   (w_find_idx)
    );

    // A done pulse only counts for a core that actually holds a character.
    assign w_done       = bus.core_done & ~r_free;
    assign w_prefix_str = insert_byte(r_template, PREFIX_BYTE, r_next_char);
    assign w_can_issue  = (r_state == StDispatch) && w_free_valid && !w_find_valid && !bus.abort;

    always_comb begin
        w_issue       = '0;
        w_find_result = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            w_issue[i] = w_can_issue && (w_free_idx == 3'(i));
            if (w_find_idx == 3'(i)) begin
                w_find_result = bus.core_result[i*MSG_W +: MSG_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= StIdle;
            r_template       <= '0;
            r_next_char      <= 8'(FROM_CHAR);
            r_chars_issued   <= '0;
            r_free           <= '1;
            r_core_ce        <= '0;
            r_core_reset     <= '1;
            r_core_start_str <= '0;
            r_busy           <= 1'b0;
            r_job_done       <= 1'b0;
            r_found          <= 1'b0;
            r_result_str     <= '0;
            r_found_core     <= '0;
        end else begin
            r_core_reset <= '0;
            r_job_done   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_template     <= bus.start_str;
                        r_found        <= 1'b0;
                        r_result_str   <= '0;
                        r_chars_issued <= '0;
                        r_next_char    <= 8'(FROM_CHAR);
                        r_free         <= '1;
                        r_busy         <= 1'b1;
                        r_state        <= StDispatch;
                    end
                end
                StDispatch, StDrain: begin
                    if (w_find_valid) begin
                        r_result_str <= w_find_result;
                        r_found_core <= w_find_idx;
                        r_found      <= 1'b1;
                        r_core_ce    <= '0;
                        r_core_reset <= '1;
                        r_free       <= '1;
                        r_busy       <= 1'b0;
                        r_state      <= StFinish;
                    end else if (bus.abort) begin
                        r_found      <= 1'b0;
                        r_core_ce    <= '0;
                        r_core_reset <= '1;
                        r_free       <= '1;
                        r_busy       <= 1'b0;
                        r_state      <= StFinish;
                    end else begin
                        // Freshly issued cores are still free here, so their ce stays low.
                        r_core_ce    <= ~r_free & ~bus.core_done;
                        r_free       <= (r_free | w_done) & ~w_issue;
                        r_core_reset <= w_issue;
                        for (int i = 0; i < int'(NUM_CORES); i++) begin
                            if (w_issue[i]) begin
                                r_core_start_str[i*MSG_W +: MSG_W] <= w_prefix_str;
                            end
                        end
                        if (w_can_issue) begin
                            r_chars_issued <= r_chars_issued + 8'd1;
                            if (r_next_char == 8'(TO_CHAR)) begin
                                r_state <= StDrain;
                            end else begin
                                r_next_char <= r_next_char + 8'd1;
                            end
                        end else if ((r_state == StDrain) && (&r_free)) begin
                            r_busy  <= 1'b0;
                            r_state <= StFinish;
                        end
                    end
                end
                StFinish: begin
                    r_job_done <= 1'b1;
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.core_reset     = r_core_reset;
    assign bus.core_ce        = r_core_ce;
    assign bus.core_start_str = r_core_start_str;
    assign bus.busy           = r_busy;
    assign bus.job_done       = r_job_done;
    assign bus.found          = r_found;
    assign bus.result_str     = r_result_str;
    assign bus.found_core     = r_found_core;
    assign bus.chars_issued   = r_chars_issued;

endmodule

// File: tb/tb_md5_bf_dispatcher.sv
// Scoreboard bench: two model engines, expected issues and job outcomes queued at stimulus time.
module tb_md5_bf_dispatcher;

    localparam int unsigned NC = 2;
    localparam int unsigned MW = 512;

    typedef struct {
        int        core;
        logic [7:0] ch;
    } issue_t;

    typedef struct {
        logic          found;
        logic [2:0]    core;
        logic [MW-1:0] res;
        logic [7:0]    chars;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    md5_bf_dispatcher_if #(.NUM_CORES(NC)) bus ();

    md5_bf_dispatcher #(
        .NUM_CORES   (NC),
        .PREFIX_BYTE (0),
        .FROM_CHAR   (65),
        .TO_CHAR     (68)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    issue_t iss_q[$];
    job_t   job_q[$];
    logic [MW-1:0] cur_tmpl = '0;
    logic          eng_auto = 1'b1;
    logic [NC-1:0] force_done = '0;
    int            cnt[NC];

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_issue(input int core, input logic [7:0] ch);
        issue_t e;
        e.core = core;
        e.ch   = ch;
        iss_q.push_back(e);
    endtask

    task automatic push_job(input logic f, input logic [2:0] c, input logic [MW-1:0] r,
                            input logic [7:0] n);
        job_t j;
        j.found = f;
        j.core  = c;
        j.res   = r;
        j.chars = n;
        job_q.push_back(j);
    endtask

    task automatic start_job(input logic [MW-1:0] t);
        cur_tmpl      = t;
        bus.start_str = t;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int k = 0; k < limit && !bus.job_done; k++) step();
        if (!bus.job_done) check("job_done_timeout", 0, 1);
        step();
    endtask

    // Engine model: done 10 cycles of ce after restart, plus forced pulses.
    always @(negedge clk) begin
        logic [NC-1:0] d;
        d = force_done;
        for (int i = 0; i < int'(NC); i++) begin
            if (bus.core_reset[i]) begin
                cnt[i] = 0;
            end else if (bus.core_ce[i]) begin
                cnt[i] = cnt[i] + 1;
                if (eng_auto && cnt[i] == 10) d[i] = 1'b1;
            end
        end
        bus.core_done = d;
    end

    // Output monitor: pops issue and job scoreboards.
    always @(negedge clk) begin
        if ($onehot(bus.core_reset)) begin
            if (iss_q.size() == 0) begin
                check("issue_unexpected", bus.core_reset, 0);
            end else begin
                issue_t e;
                int idx;
                logic [MW-1:0] exp_str;
                e   = iss_q.pop_front();
                idx = (bus.core_reset[1]) ? 1 : 0;
                exp_str = cur_tmpl;
                exp_str[MW-1 -: 8] = e.ch;
                check("issue_core", idx, e.core);
                check("issue_str", bus.core_start_str[idx*MW +: MW], exp_str);
                check("issue_ce_low", bus.core_ce[idx], 0);
            end
        end
        if (bus.job_done) begin
            if (job_q.size() == 0) begin
                check("job_unexpected", 1, 0);
            end else begin
                job_t j;
                j = job_q.pop_front();
                check("job_found", bus.found, j.found);
                check("job_result", bus.result_str, j.res);
                check("job_chars", bus.chars_issued, j.chars);
                check("job_busy", bus.busy, 0);
                if (j.found) check("job_core", bus.found_core, j.core);
            end
        end
    end

    logic [MW-1:0] res_a, res_b;

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.start_str   = '0;
        bus.core_find   = '0;
        bus.core_result = '0;
        res_a = {32'h41424344, 480'd0};
        res_b = {32'h5a5a1234, 480'd7};

        // Reset state
        step();
        step();
        check("rst_core_reset", bus.core_reset, 2'b11);
        check("rst_core_ce", bus.core_ce, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_chars", bus.chars_issued, 0);
        rst = 1'b0;
        step();
        check("rst_release_core_reset", bus.core_reset, 0);

        // Full job, no match
        push_issue(0, "A"); push_issue(1, "B"); push_issue(0, "C"); push_issue(1, "D");
        push_job(1'b0, 3'd0, '0, 8'd4);
        start_job({16{32'hcafef00d}});
        check("t1_busy", bus.busy, 1);
        wait_done(80);
        check("t1_iss_q_empty", iss_q.size(), 0);
        step();

        // Core 1 matches while core 0 runs
        push_issue(0, "A"); push_issue(1, "B");
        push_job(1'b1, 3'd1, res_a, 8'd2);
        start_job({16{32'h01020304}});
        repeat (5) step();
        check("t2_both_ce", bus.core_ce, 2'b11);
        bus.core_find   = 2'b10;
        bus.core_result = {res_a, res_b};
        step();
        bus.core_find = '0;
        check("t2_ce_drop", bus.core_ce, 0);
        check("t2_core_reset", bus.core_reset, 2'b11);
        check("t2_found", bus.found, 1);
        check("t2_found_core", bus.found_core, 1);
        check("t2_done_early", bus.job_done, 0);
        step();
        check("t2_done_lat", bus.job_done, 1);
        step();
        step();

        // Simultaneous matches: lowest index wins
        push_issue(0, "A"); push_issue(1, "B");
        push_job(1'b1, 3'd0, res_b, 8'd2);
        start_job({16{32'h11111111}});
        repeat (5) step();
        bus.core_find   = 2'b11;
        bus.core_result = {res_a, res_b};
        step();
        bus.core_find = '0;
        check("t3_found_core", bus.found_core, 0);
        wait_done(5);
        step();

        // Abort after two issues; start during job ignored
        push_issue(0, "A"); push_issue(1, "B");
        push_job(1'b0, 3'd0, '0, 8'd2);
        start_job({16{32'h22222222}});
        step();
        step();
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.start_str = {16{32'h33333333}};
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("t4_ce_stop", bus.core_ce, 0);
        check("t4_core_reset", bus.core_reset, 2'b11);
        check("t4_busy", bus.busy, 0);
        wait_done(5);
        repeat (3) step();
        check("t4_idle_after", bus.busy, 0);

        // Reset in the middle of DRAIN
        push_issue(0, "A"); push_issue(1, "B"); push_issue(0, "C"); push_issue(1, "D");
        start_job({16{32'h44444444}});
        repeat (16) step();
        check("t5_busy_drain", bus.busy, 1);
        check("t5_chars_drain", bus.chars_issued, 4);
        rst = 1'b1;
        step();
        check("t5_busy", bus.busy, 0);
        check("t5_core_reset", bus.core_reset, 2'b11);
        check("t5_core_ce", bus.core_ce, 0);
        check("t5_core_str", bus.core_start_str, 0);
        check("t5_found", bus.found, 0);
        check("t5_result", bus.result_str, 0);
        check("t5_chars", bus.chars_issued, 0);
        check("t5_job_done", bus.job_done, 0);
        rst = 1'b0;
        step();
        check("t5_core_reset_rel", bus.core_reset, 0);
        check("t5_iss_q_empty", iss_q.size(), 0);

        // Done and find on the same core in the same cycle
        eng_auto = 1'b0;
        push_issue(0, "A"); push_issue(1, "B");
        push_job(1'b1, 3'd0, res_b, 8'd2);
        start_job({16{32'h55555555}});
        repeat (5) step();
        bus.core_find   = 2'b01;
        bus.core_result = {res_a, res_b};
        force_done      = 2'b01;
        step();
        bus.core_find = '0;
        force_done    = '0;
        check("t6_found", bus.found, 1);
        check("t6_core_reset", bus.core_reset, 2'b11);
        wait_done(5);
        repeat (3) step();

        check("end_iss_q_empty", iss_q.size(), 0);
        check("end_job_q_empty", job_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
